fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode stage. Holds the PC and drives a ready/valid instruction-memory port. Registers the fetched word with PC+4/PC+8 for decode. Applies decode-resolved branch/jump targets after the delay slot, and eret/exception redirects immediately with a flush.

---
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer,
// delayed (delay-slot) branch/jump redirect and immediate eret/exception flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                Branch,
  input  logic [1:0]          Jump,
  input  logic [31:0]         PC_Beq,
  input  logic [31:0]         PC_J,
  input  logic [31:0]         PC_Jr,
  input  logic                eret,
  input  logic [31:0]         EPC,
  input  logic                exc_req,
  fetch_stage_if.master       imem,
  output logic [31:0]         instr,
  output logic [31:0]         PC4,
  output logic [31:0]         PC8,
  output logic                valid_d,
  output logic                adel
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d_int;
  logic        adel_q, adel_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_word_q, buf_word_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  // Misaligned PCs never reach memory; they "complete" instantly with a zero word.
  logic        misaligned;
  logic        complete;
  logic        flush;
  logic        capture;
  logic [31:0] cap_tgt;
  logic [31:0] fetched_word;
  logic [31:0] seq_next_pc;

  assign misaligned   = |pc_q[1:0];
  assign complete     = (state_q == S_FETCH) && (misaligned || imem.ready);
  assign flush        = exc_req | eret;
  assign capture      = valid_q && !stall && ((Jump == 2'b01) || (Jump == 2'b10) || Branch);
  assign cap_tgt      = (Jump == 2'b01) ? PC_J : (Jump == 2'b10) ? PC_Jr : PC_Beq;
  assign fetched_word = misaligned ? 32'h0 : imem.rdata;
  // A redirect seen this cycle is newer than one already pending.
  assign seq_next_pc  = capture ? cap_tgt : (pend_q ? tgt_q : pc_q + 32'd4);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: flush always lands in FETCH
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: if (complete && stall) state_d = S_HOLD;
        S_HOLD:  if (!stall) state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Memory port outputs: request only from FETCH with an aligned PC
  always_comb begin
    imem.req  = (state_q == S_FETCH) && !misaligned;
    imem.addr = pc_q;
  end

  // Datapath next values: PC, redirect bookkeeping, skid buffer, IF/ID
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    pc8_d       = pc8_q;
    valid_d_int = valid_q;
    adel_d      = adel_q;
    pend_d      = pend_q;
    tgt_d       = tgt_q;
    buf_word_d  = buf_word_q;
    buf_pc_d    = buf_pc_q;
    if (flush) begin
      pc_d        = exc_req ? EXC_VECTOR : EPC;
      instr_d     = 32'h0;
      valid_d_int = 1'b0;
      adel_d      = 1'b0;
      pend_d      = 1'b0;
    end else begin
      if (capture) begin
        tgt_d  = cap_tgt;
        pend_d = 1'b1;
      end
      case (state_q)
        S_FETCH: begin
          if (complete) begin
            pc_d   = seq_next_pc;
            pend_d = 1'b0;
            if (stall) begin
              buf_word_d = fetched_word;
              buf_pc_d   = pc_q;
            end else begin
              instr_d     = fetched_word;
              pc4_d       = pc_q + 32'd4;
              pc8_d       = pc_q + 32'd8;
              valid_d_int = 1'b1;
              adel_d      = misaligned;
            end
          end else if (!stall) begin
            instr_d     = 32'h0;
            valid_d_int = 1'b0;
            adel_d      = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_d     = buf_word_q;
            pc4_d       = buf_pc_q + 32'd4;
            pc8_d       = buf_pc_q + 32'd8;
            valid_d_int = 1'b1;
            adel_d      = |buf_pc_q[1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      pc4_q      <= 32'h0;
      pc8_q      <= 32'h0;
      valid_q    <= 1'b0;
      adel_q     <= 1'b0;
      pend_q     <= 1'b0;
      tgt_q      <= 32'h0;
      buf_word_q <= 32'h0;
      buf_pc_q   <= 32'h0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      pc8_q      <= pc8_d;
      valid_q    <= valid_d_int;
      adel_q     <= adel_d;
      pend_q     <= pend_d;
      tgt_q      <= tgt_d;
      buf_word_q <= buf_word_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  assign instr   = instr_q;
  assign PC4     = pc4_q;
  assign PC8     = pc8_q;
  assign valid_d = valid_q;
  assign adel    = adel_q;

endmodule
